bus_timer: RTL and testbench

- Memory-mapped 32-bit timer peripheral on the bridge's data bus, directly downstream of the single-cycle CPU's Bus_addr/Bus_wdata/Bus_wen/Bus_rdata interface.
- The bridge decodes the timer's address window and forwards a word offset, the write enable and the write data; the timer returns read data in the same cycle.
- Provides a programmable prescaler, compare match, one-shot or auto-reload modes, and a sticky match flag.

---
 rtl/bus_timer.sv | 130 +++++++++++++
 tb/tb_bus_timer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit timer: prescaler, compare match, one-shot/auto-reload, sticky MATCH.
// Optional interrupt output enabled by defining TIMER_IRQ_EN; otherwise irq is tied low.
module bus_timer #(
  parameter int          PRESCALE_W  = 16,
  parameter logic [31:0] RST_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  addr,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                state_q, state_d;
  logic                  auto_q, auto_d;
  logic                  ie_q, ie_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic [31:0]           cmp_q, cmp_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  match_q, match_d;

  logic                  wr_ctrl, wr_pre, wr_cmp, wr_cnt, wr_stat;
  logic                  running, tick, hit, en;
  logic [31:0]           cnt_inc;

  assign wr_ctrl = wen && (addr == 3'd0);
  assign wr_pre  = wen && (addr == 3'd1);
  assign wr_cmp  = wen && (addr == 3'd2);
  assign wr_cnt  = wen && (addr == 3'd3);
  assign wr_stat = wen && (addr == 3'd4);

  assign running = (state_q == RUN);
  assign tick    = running && (psc_q == pre_q);
  assign cnt_inc = cnt_q + 32'd1;
  // A COUNT write in the tick cycle suppresses match evaluation entirely.
  assign hit     = tick && !wr_cnt && (cnt_inc == cmp_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (wr_ctrl) begin
      state_d = wdata[0] ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN:     if (hit && !auto_q) state_d = DONE;
        IDLE:    state_d = IDLE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    en = (state_q == RUN);
  end

  always_comb begin
    auto_d  = wr_ctrl ? wdata[1] : auto_q;
    ie_d    = wr_ctrl ? wdata[2] : ie_q;
    pre_d   = wr_pre  ? wdata[PRESCALE_W-1:0] : pre_q;
    cmp_d   = wr_cmp  ? wdata : cmp_q;
    psc_d   = psc_q;
    cnt_d   = cnt_q;
    match_d = match_q;

    if (wr_cnt) begin
      cnt_d = wdata;
      psc_d = '0;
    end else if (running) begin
      // Prescaler only wraps on equality, so a shrunken PRESCALE runs to the natural wrap.
      psc_d = tick ? '0 : psc_q + 1'b1;
      if (tick) begin
        if (hit) cnt_d = auto_q ? 32'd0 : cmp_q;
        else     cnt_d = cnt_inc;
      end
    end

    if (hit)                     match_d = 1'b1;
    else if (wr_stat && wdata[0]) match_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      auto_q  <= 1'b0;
      ie_q    <= 1'b0;
      pre_q   <= '0;
      psc_q   <= '0;
      cmp_q   <= RST_COMPARE;
      cnt_q   <= 32'd0;
      match_q <= 1'b0;
    end else begin
      auto_q  <= auto_d;
      ie_q    <= ie_d;
      pre_q   <= pre_d;
      psc_q   <= psc_d;
      cmp_q   <= cmp_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      3'd0:    rdata = {29'd0, ie_q, auto_q, en};
      3'd1:    rdata = 32'(pre_q);
      3'd2:    rdata = cmp_q;
      3'd3:    rdata = cnt_q;
      3'd4:    rdata = {31'd0, match_q};
      default: rdata = 32'd0;
    endcase
  end

`ifdef TIMER_IRQ_EN
  // Driven purely from flops, so no bus-to-irq combinational path exists.
  assign irq = match_q & ie_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed scenarios plus randomized bus traffic vs. a behavioural model.
module tb_bus_timer;

  localparam int PW = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [2:0]  addr  = 3'd0;
  logic        wen   = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_rd;

  // Behavioural model state
  bit          m_run, m_auto, m_ie, m_match;
  logic [PW-1:0] m_pre, m_psc;
  logic [31:0] m_cmp, m_cnt;

`ifdef TIMER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  bus_timer #(.PRESCALE_W(PW), .RST_COMPARE(32'hFFFF_FFFF)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr(addr), .wen(wen),
    .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void mreset();
    m_run = 0; m_auto = 0; m_ie = 0; m_match = 0;
    m_pre = '0; m_psc = '0; m_cmp = 32'hFFFF_FFFF; m_cnt = 32'd0;
  endfunction

  function automatic logic [31:0] mread(input logic [2:0] a);
    case (a)
      3'd0:    return {29'd0, m_ie, m_auto, m_run};
      3'd1:    return 32'(m_pre);
      3'd2:    return m_cmp;
      3'd3:    return m_cnt;
      3'd4:    return {31'd0, m_match};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mirq();
    return {31'd0, IRQ_ON & m_match & m_ie};
  endfunction

  // One clock of timer behaviour, using state from before the edge.
  function automatic void mstep(input logic [2:0] a, input bit we, input logic [31:0] d);
    bit hit = 0;
    bit nrun = m_run;
    logic [31:0] next = m_cnt + 32'd1;
    if (we && a == 3'd3) begin
      m_cnt = d;
      m_psc = '0;
    end else if (m_run) begin
      if (m_psc == m_pre) begin
        m_psc = '0;
        if (next == m_cmp) begin
          hit = 1;
          if (m_auto) m_cnt = 32'd0;
          else begin m_cnt = m_cmp; nrun = 0; end
        end else m_cnt = next;
      end else m_psc = m_psc + 1'b1;
    end
    if (we && a == 3'd0) begin
      nrun = d[0]; m_auto = d[1]; m_ie = d[2];
    end
    if (we && a == 3'd1) m_pre = d[PW-1:0];
    if (we && a == 3'd2) m_cmp = d;
    if (hit) m_match = 1;
    else if (we && a == 3'd4 && d[0]) m_match = 0;
    m_run = nrun;
  endfunction

  task automatic cyc(input logic [2:0] a, input bit we, input logic [31:0] d);
    addr = a; wen = we; wdata = d;
    @(negedge clk_i);
    last_rd = rdata;
    chk($sformatf("rd%0d", a), rdata, mread(a));
    chk("irq", {31'd0, irq}, mirq());
    @(posedge clk_i);
    mstep(a, we, d);
    #1;
    wen = 1'b0;
  endtask

  function automatic logic [31:0] rst_exp(input int i);
    return (i == 2) ? 32'hFFFF_FFFF : 32'd0;
  endfunction

  task automatic async_reset();
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      addr = 3'(i);
      #1;
      chk($sformatf("rst_rd%0d", i), rdata, rst_exp(i));
    end
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    mreset();
    @(posedge clk_i);
    #1;
  endtask

  task automatic setup(input logic [31:0] pre, input logic [31:0] cmp, input logic [31:0] ctrl);
    cyc(3'd0, 1, 32'd0);
    cyc(3'd4, 1, 32'd1);
    cyc(3'd3, 1, 32'd0);
    cyc(3'd1, 1, pre);
    cyc(3'd2, 1, cmp);
    cyc(3'd0, 1, ctrl);
  endtask

  initial begin
    bit found;
    bit seen;
    mreset();
    async_reset();

    // One-shot
    setup(32'd3, 32'd5, 32'd1);
    for (int i = 0; i < 24; i++) cyc(3'd3, 0, 32'd0);
    chk("os_cnt", last_rd, 32'd5);
    cyc(3'd4, 0, 32'd0);
    chk("os_match", last_rd, 32'd1);
    cyc(3'd0, 0, 32'd0);
    chk("os_ctrl", last_rd, 32'd0);
    for (int i = 0; i < 50; i++) begin
      cyc(3'd3, 0, 32'd0);
      if (i % 10 == 9) chk("os_hold", last_rd, 32'd5);
    end

    // Auto-reload and clear/re-set
    setup(32'd0, 32'd2, 32'd3);
    for (int i = 0; i < 6; i++) cyc(3'd3, 0, 32'd0);
    cyc(3'd4, 0, 32'd0);
    chk("ar_match", last_rd, 32'd1);
    cyc(3'd4, 1, 32'd1);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(3'd4, 0, 32'd0);
      if (last_rd[0]) seen = 1;
    end
    chk("ar_reset", {31'd0, seen}, 32'd1);

    // Clear/set collision: clear lands on the cycle the match tick fires
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_cnt + 32'd1 == m_cmp) found = 1;
      else cyc(3'd3, 0, 32'd0);
    end
    chk("coll_found", {31'd0, found}, 32'd1);
    cyc(3'd4, 1, 32'd1);
    cyc(3'd4, 0, 32'd0);
    chk("coll_match", last_rd, 32'd1);

    // COUNT load during run, aligned to a tick
    setup(32'd1, 32'd102, 32'd1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_psc == m_pre) found = 1;
      else cyc(3'd3, 0, 32'd0);
    end
    chk("ld_align", {31'd0, found}, 32'd1);
    cyc(3'd3, 1, 32'd100);
    for (int k = 1; k <= 5; k++) begin
      cyc(3'd4, 0, 32'd0);
      chk($sformatf("ld_match%0d", k), last_rd, (k == 5) ? 32'd1 : 32'd0);
    end
    cyc(3'd3, 0, 32'd0);
    chk("ld_cnt", last_rd, 32'd102);

    // Interrupt enable / disable
    setup(32'd0, 32'd2, 32'd7);
    for (int i = 0; i < 3; i++) cyc(3'd4, 0, 32'd0);
    chk("irq_on", {31'd0, irq}, {31'd0, IRQ_ON});
    cyc(3'd0, 1, 32'd3);
    #1;
    chk("irq_off", {31'd0, irq}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      bit          we;
      we = ($urandom_range(0, 3) == 0);
      a  = 3'($urandom_range(0, 7));
      case (a)
        3'd0:    d = 32'($urandom_range(0, 7)) | 32'($urandom_range(0, 1));
        3'd1:    d = 32'($urandom_range(0, 3));
        3'd2:    d = 32'($urandom_range(0, 12));
        3'd3:    d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 10));
        default: d = $urandom;
      endcase
      cyc(a, we, d);
    end

    // Asynchronous reset mid-count
    setup(32'd0, 32'd1000, 32'd1);
    for (int i = 0; i < 5; i++) cyc(3'd3, 0, 32'd0);
    async_reset();
    for (int i = 0; i < 4; i++) cyc(3'd3, 0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
